// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the ALU and the multiply/divide sequencer.
//   XLEN_DEF     : operand width (only 32 is supported)
//   alu_ctrl_e   : control codes understood by the combinational alu
//   muldiv_op_e  : operation select carried on req_op
package alu_defs;

  localparam int XLEN_DEF = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    MD_MUL  = 2'b00,
    MD_DIVU = 2'b01,
    MD_REMU = 2'b10,
    MD_RSVD = 2'b11
  } muldiv_op_e;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute stage and alu_muldiv_seq.
//   req_valid/req_ready : request handshake, accepted when both high
//   req_op/req_a/req_b  : operation and operands, captured on acceptance
//   resp_valid          : one-cycle result pulse
//   resp_data           : result, held until the next result
// master = execute stage, slave = sequencer.
interface alu_muldiv_seq_if;

  logic                          req_valid;
  logic                          req_ready;
  logic [1:0]                    req_op;
  logic [alu_defs::XLEN_DEF-1:0] req_a;
  logic [alu_defs::XLEN_DEF-1:0] req_b;
  logic                          resp_valid;
  logic [alu_defs::XLEN_DEF-1:0] resp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, resp_valid, resp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/alu_muldiv_seq_alu.sv
// Combinational ALU shared by the sequencer for its add/sub/compare steps.
//   a, b   : operands
//   ctrl   : operation (alu_ctrl_e)
//   result : operation result
//   zero   : result == 0
module alu
  import alu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_ctrl_e       ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int SW = $clog2(XLEN);

  logic [SW-1:0] shamt;
  assign shamt = b[SW-1:0];

  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, a < b};
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle MUL / DIVU / REMU sequencer built around one combinational alu.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu_muldiv_seq_if (valid/ready request,
//           single-cycle resp_valid pulse with resp_data)
// MUL is shift-and-add (one cycle per multiplier bit up to its top set bit);
// DIVU/REMU is restoring division (compare cycle per bit, plus a subtract
// cycle for every quotient bit that is 1).
module alu_muldiv_seq
  import alu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE, S_MUL_RUN, S_DIV_CMP, S_DIV_SUB, S_DONE
  } state_e;

  state_e          state_reg, state_next;
  logic [XLEN-1:0] acc_reg, acc_next;
  logic [XLEN-1:0] mcand_reg, mcand_next;
  logic [XLEN-1:0] mplier_reg, mplier_next;
  logic [XLEN-1:0] rem_reg, rem_next;
  logic [XLEN-1:0] quot_reg, quot_next;
  logic [XLEN-1:0] div_reg, div_next;
  logic [1:0]      op_reg, op_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            ready_reg, ready_next;
  logic            resp_valid_reg, resp_valid_next;
  logic [XLEN-1:0] resp_data_reg, resp_data_next;

  logic [XLEN-1:0] alu_a, alu_b, alu_result, shifted;
  alu_ctrl_e       alu_ctrl;
  logic            alu_zero_unused;

  alu #(.XLEN(XLEN)) u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .ctrl   (alu_ctrl),
    .result (alu_result),
    .zero   (alu_zero_unused)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      acc_reg        <= '0;
      mcand_reg      <= '0;
      mplier_reg     <= '0;
      rem_reg        <= '0;
      quot_reg       <= '0;
      div_reg        <= '0;
      op_reg         <= '0;
      cnt_reg        <= '0;
      ready_reg      <= 1'b1;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      mcand_reg      <= mcand_next;
      mplier_reg     <= mplier_next;
      rem_reg        <= rem_next;
      quot_reg       <= quot_next;
      div_reg        <= div_next;
      op_reg         <= op_next;
      cnt_reg        <= cnt_next;
      ready_reg      <= ready_next;
      resp_valid_reg <= resp_valid_next;
      resp_data_reg  <= resp_data_next;
    end
  end

  // Remainder picks up the next dividend bit from the top of quot.
  assign shifted = {rem_reg[XLEN-2:0], quot_reg[XLEN-1]};

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    mcand_next     = mcand_reg;
    mplier_next    = mplier_reg;
    rem_next       = rem_reg;
    quot_next      = quot_reg;
    div_next       = div_reg;
    op_next        = op_reg;
    cnt_next       = cnt_reg;
    resp_data_next = resp_data_reg;
    alu_a          = '0;
    alu_b          = '0;
    alu_ctrl       = ALU_ADD;

    case (state_reg)
      S_IDLE: begin
        if (bus.req_valid) begin
          op_next = bus.req_op;
          case (bus.req_op)
            MD_MUL: begin
              if (bus.req_a == '0 || bus.req_b == '0) begin
                resp_data_next = '0;
                state_next     = S_DONE;
              end else begin
                acc_next    = '0;
                mcand_next  = bus.req_a;
                mplier_next = bus.req_b;
                state_next  = S_MUL_RUN;
              end
            end
            MD_DIVU, MD_REMU: begin
              div_next = bus.req_b;
              if (bus.req_b == '0) begin
                resp_data_next = (bus.req_op == MD_DIVU) ? '1 : bus.req_a;
                state_next     = S_DONE;
              end else begin
                rem_next   = '0;
                quot_next  = bus.req_a;
                cnt_next   = CW'(XLEN-1);
                state_next = S_DIV_CMP;
              end
            end
            default: begin
              resp_data_next = '0;
              state_next     = S_DONE;
            end
          endcase
        end
      end

      S_MUL_RUN: begin
        alu_a    = acc_reg;
        alu_b    = mcand_reg;
        alu_ctrl = ALU_ADD;
        if (mplier_reg[0]) acc_next = alu_result;
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        // Stop as soon as no set multiplier bits remain.
        if (mplier_next == '0) begin
          resp_data_next = acc_next;
          state_next     = S_DONE;
        end
      end

      S_DIV_CMP: begin
        alu_a     = shifted;
        alu_b     = div_reg;
        alu_ctrl  = ALU_SLTU;
        rem_next  = shifted;
        quot_next = {quot_reg[XLEN-2:0], 1'b0};
        if (!alu_result[0]) begin
          state_next = S_DIV_SUB;
        end else begin
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            resp_data_next = (op_reg == MD_DIVU) ? quot_next : rem_next;
            state_next     = S_DONE;
          end
        end
      end

      S_DIV_SUB: begin
        alu_a     = rem_reg;
        alu_b     = div_reg;
        alu_ctrl  = ALU_SUB;
        rem_next  = alu_result;
        quot_next = {quot_reg[XLEN-1:1], 1'b1};
        cnt_next  = cnt_reg - CW'(1);
        if (cnt_reg == '0) begin
          resp_data_next = (op_reg == MD_DIVU) ? quot_next : rem_next;
          state_next     = S_DONE;
        end else begin
          state_next = S_DIV_CMP;
        end
      end

      S_DONE: state_next = S_IDLE;

      default: state_next = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ready_next      = (state_next == S_IDLE);
    resp_valid_next = (state_next == S_DONE);
  end

  assign bus.req_ready  = ready_reg;
  assign bus.resp_valid = resp_valid_reg;
  assign bus.resp_data  = resp_data_reg;

endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Multi-cycle sequencer that runs RV32M-style MUL, DIVU and REMU on one instance of the existing combinational `alu`. The ALU provides the add, subtract and compare steps; this block holds operands, shift registers and an iteration FSM. It sits beside the execute stage and uses a valid/ready request and a single-cycle response pulse, so the pipeline stalls while `req_ready` is low.

## Interface
- `XLEN`, default 32: operand width. Only 32 is supported.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE.
- `req_op`  in  2  operation select:
  - 00 MUL (low 32 bits of the product).
  - 01 DIVU.
  - 10 REMU.
  - 11 reserved.
- `req_a`  in  32  multiplicand or dividend.
- `req_b`  in  32  multiplier or divisor.
- `resp_valid`  out  1  one-cycle pulse in DONE.
- `resp_data`  out  32  result. Valid while `resp_valid` is high and held until the next acceptance.

## Operation
- Reset values:
  - state = IDLE.
  - `req_ready` = 1, `resp_valid` = 0, `resp_data` = 0.
  - All internal registers = 0.
- Acceptance happens on a rising edge where `req_valid && req_ready`.
  - Operands and op are captured at that edge; later input changes are ignored.
  - `req_valid` while busy is ignored, with no queueing.
- FSM states: IDLE, MUL_RUN, DIV_CMP, DIV_SUB, DONE.
- From IDLE on acceptance:
  - op=11 goes to DONE with result 0.
  - MUL with a==0 or b==0 goes to DONE with result 0.
  - DIVU or REMU with b==0 goes to DONE with result 0xFFFFFFFF (DIVU) or a (REMU).
  - Other MUL goes to MUL_RUN.
  - Other DIVU/REMU goes to DIV_CMP with rem=0, quot=a, cnt=31.
- MUL_RUN, one cycle per multiplier bit:
  - ALU is driven with ADD(acc, mcand).
  - If mplier[0] is 1, acc ← alu result.
  - mcand ← mcand<<1 and mplier ← mplier>>1; the shifts are done locally, not by the ALU.
  - Go to DONE when the shifted mplier == 0; otherwise stay.
  - Overflow above bit 31 is discarded.
- DIV_CMP, one per quotient bit, restoring division:
  - shifted = {rem[30:0], quot[31]}.
  - ALU is driven with SLTU(shifted, b).
  - rem and quot are always updated to the shifted values (quot LSB = 0 for now).
  - If the SLTU result is 0 (shifted ≥ b), go to DIV_SUB.
  - Otherwise decrement cnt; go to DONE if cnt was 0, else stay in DIV_CMP.
- DIV_SUB:
  - ALU is driven with SUB(rem, b); rem ← result and quot[0] ← 1.
  - Decrement cnt; go to DONE if cnt was 0, else back to DIV_CMP.
- No 33-bit carry handling is needed: rem < 2^31 whenever a bit remains to be shifted in.
- DONE:
  - `resp_valid` = 1 for exactly one cycle.
  - `resp_data` = acc (MUL), quot (DIVU) or rem (REMU).
  - Next state is IDLE.
- While the ALU is not used (IDLE, DONE), it is driven ADD(0,0).

## Timing
- Cycle N is the cycle whose closing edge accepts the request. All outputs are registered.
- Early-exit cases (zero operand, divide by zero, reserved op): `resp_valid` at N+1.
- MUL: k = index of highest set bit of b, plus 1. k MUL_RUN cycles, then `resp_valid` at N+k+1.
- DIVU/REMU: 32 + popcount(quotient) cycles of DIV_CMP/DIV_SUB, then `resp_valid` at N+33+popcount(q).
- Back-to-back: `req_ready` returns high the cycle after DONE. The minimum request spacing is 2 cycles.
- `rst_n` asserted mid-operation:
  - Returns to IDLE immediately, with outputs at reset values.
  - No `resp_valid` is ever produced for the aborted request.

## Structure
- Shared package `alu_defs`:
  - ALU control codes ADD=4'b0000, SUB=4'b0001, SLTU=4'b1001, plus the remaining codes.
  - MULDIV op codes MUL=2'b00, DIVU=2'b01, REMU=2'b10.
- FSM state encoding stays local to this block.
- One sub-module: instance `u_alu` of `alu`. Its `zero` output is unused.

## Test plan
- MUL a=3, b=5 accepted at N -> `resp_valid` at N+4, `resp_data`=15, `req_ready` low over N+1..N+4.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> `resp_data`=0x00000001 at N+33. MUL a=7, b=0 -> 0 at N+1.
- DIVU 100/7 -> 14 at N+36; REMU 100/7 -> 2 at N+36. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF at N+65.
- DIVU 0x1234/0 -> 0xFFFFFFFF at N+1; REMU 0x1234/0 -> 0x1234 at N+1; op=11 -> 0 at N+1.
- Hold `req_valid` high with new operands during a busy DIVU -> ignored, and the first result is unaffected. The second request is accepted in the IDLE cycle after DONE.
- Assert `rst_n` low at N+10 of a DIVU -> outputs zero immediately and no response pulse follows. After release, MUL 6×7 -> 42 at N'+4.
